// File: rtl/display_scan_driver.sv
// Binary-to-packed-BCD converter (sequential double-dabble) feeding a time-multiplexed,
// common-anode 7-segment digit scan. Optional feature macro: LEADING_ZERO_BLANK_EN.
module display_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_WIDTH   = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_WIDTH-1:0]  value_i,
  input  logic                  load_i,
  output logic                  busy_o,
  output logic                  ovf_o,
  output logic [3:0]            digit_o,
  output logic [NUM_DIGITS-1:0] anode_n_o
);

  localparam int WORK_DIGITS = NUM_DIGITS + 1;
  localparam int CNT_W       = $clog2(REFRESH_DIV);
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int ITER_W      = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(BIN_WIDTH - 1);
  localparam logic [3:0]        BLANK     = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_COMMIT
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              capture;
  logic              step;
  logic              commit;

  logic [BIN_WIDTH-1:0] shift_q;
  logic [ITER_W-1:0]    iter_q;
  logic [3:0]           work_q       [WORK_DIGITS];
  logic [3:0]           work_adj     [WORK_DIGITS];
  logic [3:0]           work_next    [WORK_DIGITS];

  logic [3:0]           disp_q       [NUM_DIGITS];
  logic [3:0]           commit_digit [NUM_DIGITS];
  logic                 commit_ovf;

  logic [CNT_W-1:0]     refresh_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 wrap;
  logic [3:0]           scan_digit;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value held and infer a latch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (load_i) begin
          capture    = 1'b1;
          state_next = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        step = 1'b1;
        if (iter_q == ITER_LAST) begin
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        commit     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy_o = (state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Double-dabble step: add 3 to each nibble >= 5, then shift the whole
  // {bcd, binary} chain left by one.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < WORK_DIGITS; i++) begin
      work_adj[i] = (work_q[i] >= 4'd5) ? work_q[i] + 4'd3 : work_q[i];
    end
  end

  always_comb begin
    work_next[0] = {work_adj[0][2:0], shift_q[BIN_WIDTH-1]};
    for (int i = 1; i < WORK_DIGITS; i++) begin
      work_next[i] = {work_adj[i][2:0], work_adj[i-1][3]};
    end
  end

  // The extra top digit only becomes nonzero when the value cannot be shown.
  always_comb begin
    commit_ovf = (work_q[NUM_DIGITS] != 4'd0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      commit_digit[i] = commit_ovf ? 4'd9 : work_q[i];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_next;
  logic [NUM_DIGITS-1:0] blank_q;

  // Walk from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    logic seen_nonzero;
    seen_nonzero = 1'b0;
    blank_next   = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (commit_digit[i] != 4'd0) begin
        seen_nonzero = 1'b1;
      end
      blank_next[i] = !seen_nonzero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else if (commit) begin
      blank_q <= blank_next;
    end
  end

  assign scan_digit = blank_q[idx_q] ? BLANK : disp_q[idx_q];
`else
  assign scan_digit = disp_q[idx_q];
`endif

  // ---------------------------------------------------------------------------
  // Conversion datapath and display register
  // ---------------------------------------------------------------------------
  // NOTE: the display register array is reset explicitly; it is a handful of
  // flops that must read as zero after reset, not an inferred RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      iter_q  <= '0;
      ovf_o   <= 1'b0;
      for (int i = 0; i < WORK_DIGITS; i++) begin
        work_q[i] <= '0;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        disp_q[i] <= '0;
      end
    end else begin
      if (capture) begin
        shift_q <= value_i;
        iter_q  <= '0;
        for (int i = 0; i < WORK_DIGITS; i++) begin
          work_q[i] <= '0;
        end
      end else if (step) begin
        shift_q <= shift_q << 1;
        iter_q  <= iter_q + ITER_W'(1);
        for (int i = 0; i < WORK_DIGITS; i++) begin
          work_q[i] <= work_next[i];
        end
      end

      if (commit) begin
        ovf_o <= commit_ovf;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          disp_q[i] <= commit_digit[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit scan: outputs move only on wrap edges, and a same-edge COMMIT is
  // seen one wrap later because disp_q is sampled before it updates.
  // ---------------------------------------------------------------------------
  assign wrap = (refresh_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
      idx_q     <= '0;
      digit_o   <= BLANK;
      anode_n_o <= '1;
    end else begin
      refresh_q <= wrap ? '0 : refresh_q + CNT_W'(1);
      if (wrap) begin
        digit_o   <= scan_digit;
        anode_n_o <= ~(NUM_DIGITS'(1) << idx_q);
        idx_q     <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench for display_scan_driver: arithmetic reference of the shown digits,
// scan position derived from the cycle count since reset release.
module tb_display_scan_driver;

  localparam int ND   = 4;
  localparam int BW   = 14;
  localparam int RD   = 4;
  localparam int MAXV = 9999;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic [BW-1:0] value_i = '0;
  logic          load_i  = 1'b0;
  logic          busy_o;
  logic          ovf_o;
  logic [3:0]    digit_o;
  logic [ND-1:0] anode_n_o;

  int assertions  = 0;
  int failures    = 0;
  int cyc         = 0;
  int model_value = 0;
  bit model_ovf   = 1'b0;

  display_scan_driver #(
    .NUM_DIGITS (ND),
    .BIN_WIDTH  (BW),
    .REFRESH_DIV(RD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value_i  (value_i),
    .load_i   (load_i),
    .busy_o   (busy_o),
    .ovf_o    (ovf_o),
    .digit_o  (digit_o),
    .anode_n_o(anode_n_o)
  );

  always #5 clk = ~clk;

  // Edge count since reset release: edge m is a wrap edge when m % RD == 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [3:0] exp_digit(input int v, input int idx);
    int d;
    d = (v / pow10(idx)) % 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && v < pow10(idx)) return 4'hF;
`endif
    return 4'(d);
  endfunction

  function automatic logic [ND-1:0] exp_anode(input int idx);
    logic [ND-1:0] a;
    a = '1;
    if (idx >= 0 && idx < ND) a[idx] = 1'b0;
    return a;
  endfunction

  task automatic commit_model(input int v);
    model_ovf   = (v > MAXV);
    model_value = model_ovf ? MAXV : v;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus / synchronisation helpers (no comparisons inside)
  // ---------------------------------------------------------------------------
  task automatic do_load(input int v, output int k);
    @(negedge clk);
    value_i = BW'(v);
    load_i  = 1'b1;
    @(posedge clk);
    #1;
    k      = cyc;
    load_i = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int drop);
    drop = -1;
    for (int n = 0; n < limit; n++) begin
      @(posedge clk);
      #1;
      if (!busy_o) begin
        drop = cyc;
        break;
      end
    end
  endtask

  task automatic wait_wrap(output bit ok, output int idx);
    ok  = 1'b0;
    idx = 0;
    for (int n = 0; n < 2 * RD; n++) begin
      @(posedge clk);
      #1;
      if (cyc % RD == 0) begin
        ok  = 1'b1;
        idx = ((cyc / RD) - 1) % ND;
        break;
      end
    end
  endtask

  task automatic wait_until_cyc(input int target);
    for (int n = 0; n < 64 && cyc < target; n++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    bit ok;
    int idx;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    commit_model(0);

    assertions++;
    if ({busy_o, ovf_o, digit_o, anode_n_o} !== {1'b0, 1'b0, 4'hF, {ND{1'b1}}}) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b ovf=%b digit=%h anode=%b, expected 0 0 f %b",
               busy_o, ovf_o, digit_o, anode_n_o, {ND{1'b1}});
    end

    for (int e = 1; e < RD; e++) begin
      @(posedge clk);
      #1;
      assertions++;
      if ({digit_o, anode_n_o} !== {4'hF, {ND{1'b1}}}) begin
        failures++;
        $display("FAIL reset_dark edge %0d: digit=%h anode=%b, expected f %b",
                 e, digit_o, anode_n_o, {ND{1'b1}});
      end
    end

    for (int w = 0; w < ND + 1; w++) begin
      wait_wrap(ok, idx);
      assertions++;
      if (!ok || cyc !== RD * (w + 1) ||
          {anode_n_o, digit_o} !== {exp_anode(idx), exp_digit(model_value, idx)}) begin
        failures++;
        $display("FAIL reset_scan wrap %0d: cyc=%0d anode=%b digit=%h, expected cyc=%0d anode=%b digit=%h",
                 w, cyc, anode_n_o, digit_o, RD * (w + 1), exp_anode(idx), exp_digit(model_value, idx));
      end
    end
  endtask

  task automatic test_convert();
    bit ok;
    int idx;
    int k;
    do_load(1234, k);
    assertions++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL convert_busy edge k: busy=%b, expected 1", busy_o);
    end
    for (int e = 1; e <= BW + 1; e++) begin
      @(posedge clk);
      #1;
      assertions++;
      if (busy_o !== (e < BW + 1)) begin
        failures++;
        $display("FAIL convert_busy edge k+%0d: busy=%b, expected %b", e, busy_o, (e < BW + 1));
      end
    end
    commit_model(1234);
    assertions++;
    if (ovf_o !== model_ovf) begin
      failures++;
      $display("FAIL convert_ovf: ovf=%b, expected %b", ovf_o, model_ovf);
    end
    for (int w = 0; w < ND; w++) begin
      wait_wrap(ok, idx);
      assertions++;
      if (!ok || {anode_n_o, digit_o} !== {exp_anode(idx), exp_digit(model_value, idx)}) begin
        failures++;
        $display("FAIL convert_scan: anode=%b digit=%h, expected anode=%b digit=%h",
                 anode_n_o, digit_o, exp_anode(idx), exp_digit(model_value, idx));
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int idx;
    int k;
    int drop;
    int vals[2] = '{16383, 42};
    foreach (vals[v]) begin
      do_load(vals[v], k);
      wait_idle(40, drop);
      commit_model(vals[v]);
      assertions++;
      if (drop !== k + BW + 1 || ovf_o !== model_ovf) begin
        failures++;
        $display("FAIL overflow_%0d: idle_at=%0d ovf=%b, expected idle_at=%0d ovf=%b",
                 vals[v], drop, ovf_o, k + BW + 1, model_ovf);
      end
      for (int w = 0; w < ND; w++) begin
        wait_wrap(ok, idx);
        assertions++;
        if (!ok || {anode_n_o, digit_o} !== {exp_anode(idx), exp_digit(model_value, idx)}) begin
          failures++;
          $display("FAIL overflow_%0d_scan: anode=%b digit=%h, expected anode=%b digit=%h",
                   vals[v], anode_n_o, digit_o, exp_anode(idx), exp_digit(model_value, idx));
        end
      end
    end
  endtask

  task automatic test_load_ignored();
    bit ok;
    int idx;
    int k;
    int drop;
    do_load(1234, k);
    wait_until_cyc(k + 4);
    @(negedge clk);
    value_i = BW'(5678);
    load_i  = 1'b1;
    @(posedge clk);
    #1;
    load_i = 1'b0;
    wait_idle(40, drop);
    commit_model(1234);
    assertions++;
    if (drop !== k + BW + 1) begin
      failures++;
      $display("FAIL ignored_load_busy: idle_at=%0d, expected %0d", drop, k + BW + 1);
    end
    // A queued second load would raise busy again on the following edge.
    repeat (2) @(posedge clk);
    #1;
    assertions++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL ignored_load_queued: busy=%b, expected 0", busy_o);
    end
    for (int w = 0; w < ND; w++) begin
      wait_wrap(ok, idx);
      assertions++;
      if (!ok || {anode_n_o, digit_o} !== {exp_anode(idx), exp_digit(model_value, idx)}) begin
        failures++;
        $display("FAIL ignored_load_scan: anode=%b digit=%h, expected anode=%b digit=%h",
                 anode_n_o, digit_o, exp_anode(idx), exp_digit(model_value, idx));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int idx;
    int k;
    int drop;
    do_load(16383, k);
    wait_idle(40, drop);
    assertions++;
    if (ovf_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_setup_ovf: ovf=%b, expected 1", ovf_o);
    end
    do_load(9999, k);
    wait_until_cyc(k + 7);
    rst_n = 1'b0;
    #1;
    assertions++;
    if ({busy_o, ovf_o, digit_o, anode_n_o} !== {1'b0, 1'b0, 4'hF, {ND{1'b1}}}) begin
      failures++;
      $display("FAIL reset_mid_async: busy=%b ovf=%b digit=%h anode=%b, expected 0 0 f %b",
               busy_o, ovf_o, digit_o, anode_n_o, {ND{1'b1}});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    commit_model(0);
    for (int w = 0; w < ND; w++) begin
      wait_wrap(ok, idx);
      assertions++;
      if (!ok || busy_o !== 1'b0 || ovf_o !== 1'b0 ||
          {anode_n_o, digit_o} !== {exp_anode(idx), exp_digit(model_value, idx)}) begin
        failures++;
        $display("FAIL reset_mid_scan: busy=%b ovf=%b anode=%b digit=%h, expected 0 0 anode=%b digit=%h",
                 busy_o, ovf_o, anode_n_o, digit_o, exp_anode(idx), exp_digit(model_value, idx));
      end
    end
  endtask

  task automatic test_commit_on_wrap();
    bit ok;
    int idx;
    int k;
    for (int n = 0; n < 2 * RD && (cyc % RD) != 0; n++) begin
      @(posedge clk);
      #1;
    end
    // Next edge k satisfies k % RD == 1, so COMMIT at k+BW+1 lands on a wrap.
    do_load(8765, k);
    wait_until_cyc(k + BW);
    wait_wrap(ok, idx);
    assertions++;
    if (!ok || cyc !== k + BW + 1 || busy_o !== 1'b0 ||
        {anode_n_o, digit_o} !== {exp_anode(idx), exp_digit(model_value, idx)}) begin
      failures++;
      $display("FAIL commit_wrap_old: cyc=%0d busy=%b anode=%b digit=%h, expected cyc=%0d busy=0 anode=%b digit=%h",
               cyc, busy_o, anode_n_o, digit_o, k + BW + 1, exp_anode(idx), exp_digit(model_value, idx));
    end
    commit_model(8765);
    wait_wrap(ok, idx);
    assertions++;
    if (!ok || {anode_n_o, digit_o} !== {exp_anode(idx), exp_digit(model_value, idx)}) begin
      failures++;
      $display("FAIL commit_wrap_new: anode=%b digit=%h, expected anode=%b digit=%h",
               anode_n_o, digit_o, exp_anode(idx), exp_digit(model_value, idx));
    end
  endtask

  task automatic test_random();
    bit ok;
    int idx;
    int k;
    int drop;
    int v;
    for (int t = 0; t < 10; t++) begin
      case (t)
        0:       v = MAXV;
        1:       v = MAXV + 1;
        2:       v = 0;
        3:       v = (1 << BW) - 1;
        default: v = int'($urandom_range(0, (1 << BW) - 1));
      endcase
      do_load(v, k);
      wait_idle(40, drop);
      commit_model(v);
      assertions++;
      if (drop !== k + BW + 1 || ovf_o !== model_ovf) begin
        failures++;
        $display("FAIL random_%0d: idle_at=%0d ovf=%b, expected idle_at=%0d ovf=%b",
                 v, drop, ovf_o, k + BW + 1, model_ovf);
      end
      for (int w = 0; w < ND; w++) begin
        wait_wrap(ok, idx);
        assertions++;
        if (!ok || {anode_n_o, digit_o} !== {exp_anode(idx), exp_digit(model_value, idx)}) begin
          failures++;
          $display("FAIL random_%0d_scan: anode=%b digit=%h, expected anode=%b digit=%h",
                   v, anode_n_o, digit_o, exp_anode(idx), exp_digit(model_value, idx));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_overflow();
    test_load_ignored();
    test_reset_mid();
    test_commit_on_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
